md5core_thread_sched: RTL and testbench

//  Sequences the interleaved-thread MD5 core datapath. N_THREADS contexts share one round

---
 rtl/md5core_thread_sched.sv | 88 ++++++++
 tb/tb_md5core_thread_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md5core_thread_sched.sv
// Thread scheduler for the interleaved MD5 core: slot counter, per-thread round/state
// tracking, block-load handshake and delay-line enable/reset.
module md5core_thread_sched #(
  parameter int unsigned N_THREADS = 4,
  parameter int unsigned N_ROUNDS  = 64,
  parameter int unsigned TW        = 2
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load_req,
  input  logic [TW-1:0]        load_thread,
  output logic                 load_ack,
  input  logic [N_THREADS-1:0] done_ack,
  output logic [N_THREADS-1:0] done_mask,
  output logic [TW-1:0]        slot,
  output logic                 issue_valid,
  output logic [5:0]           issue_round,
  output logic                 issue_first,
  output logic                 issue_last,
  output logic                 shreg_en,
  output logic                 shreg_rst
);

  localparam int unsigned RW = 6;
  localparam logic [TW-1:0] SLOT_MAX  = TW'(N_THREADS - 1);
  localparam logic [RW-1:0] ROUND_MAX = RW'(N_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } thr_state_t;

  thr_state_t      state_q [N_THREADS];
  logic [RW-1:0]   round_q [N_THREADS];
  logic [TW-1:0]   slot_q;

  // Issue decode straight off the registered state of the thread in the slot.
  always_comb begin
    slot        = slot_q;
    issue_valid = (state_q[slot_q] == ST_RUN);
    issue_round = round_q[slot_q];
    issue_first = issue_valid && (round_q[slot_q] == '0);
    issue_last  = issue_valid && (round_q[slot_q] == ROUND_MAX);
    load_ack    = en && !rst && load_req && (load_thread == slot_q) &&
                  (state_q[slot_q] == ST_IDLE);
    shreg_en    = en && !rst;
    shreg_rst   = rst;
    done_mask   = '0;
    for (int k = 0; k < int'(N_THREADS); k++) begin
      done_mask[k] = (state_q[k] == ST_DONE);
    end
  end

  // Only the slot thread can load or advance; done_ack touches DONE threads only, so the
  // two update paths never target the same thread in the same state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      slot_q <= '0;
      for (int k = 0; k < int'(N_THREADS); k++) begin
        state_q[k] <= ST_IDLE;
        round_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_THREADS); k++) begin
        if (done_ack[k] && (state_q[k] == ST_DONE)) begin
          state_q[k] <= ST_IDLE;
        end
      end
      if (en) begin
        slot_q <= (slot_q == SLOT_MAX) ? '0 : slot_q + TW'(1);
        if (load_ack) begin
          state_q[slot_q] <= ST_RUN;
          round_q[slot_q] <= '0;
        end else if (issue_valid) begin
          if (issue_last) begin
            round_q[slot_q] <= '0;
            state_q[slot_q] <= ST_DONE;
          end else begin
            round_q[slot_q] <= round_q[slot_q] + RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_md5core_thread_sched.sv
// Directed self-checking bench for md5core_thread_sched (4 threads, 64 rounds).
module tb_md5core_thread_sched;

  logic       CLK = 1'b0;
  logic       rst;
  logic       en;
  logic       load_req;
  logic [1:0] load_thread;
  logic       load_ack;
  logic [3:0] done_ack;
  logic [3:0] done_mask;
  logic [1:0] slot;
  logic       issue_valid;
  logic [5:0] issue_round;
  logic       issue_first;
  logic       issue_last;
  logic       shreg_en;
  logic       shreg_rst;

  int checks   = 0;
  int failures = 0;
  int exp_slot = 0;

  always #5 CLK = ~CLK;

  md5core_thread_sched #(.N_THREADS(4), .N_ROUNDS(64), .TW(2)) dut (
    .CLK(CLK), .rst(rst), .en(en), .load_req(load_req), .load_thread(load_thread),
    .load_ack(load_ack), .done_ack(done_ack), .done_mask(done_mask), .slot(slot),
    .issue_valid(issue_valid), .issue_round(issue_round), .issue_first(issue_first),
    .issue_last(issue_last), .shreg_en(shreg_en), .shreg_rst(shreg_rst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; the expected slot follows the sampled en/rst.
  task automatic tick();
    @(posedge CLK);
    if (rst) exp_slot = 0;
    else if (en) exp_slot = (exp_slot + 1) % 4;
    #2;
  endtask

  // Hold load_req until acked (bounded), leaving the bench one edge past the ack.
  task automatic do_load(input int thr, output bit ok);
    load_req    = 1'b1;
    load_thread = 2'(thr);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (load_ack) begin
        ok = 1'b1;
        chk("load_slot", 32'(slot), 32'(thr));
      end
      tick();
    end
    load_req = 1'b0;
    chk("load_acked", 32'(ok), 32'd1);
  endtask

  bit         got;
  int         cnt;
  logic [1:0] prev_slot;
  logic [5:0] prev_round;
  logic       was_en;

  initial begin
    rst = 1'b1; en = 1'b1; load_req = 1'b1; load_thread = 2'd0; done_ack = 4'b0000;

    // Reset holds everything, even with a matching load request.
    repeat (3) begin
      tick();
      chk("rst_shreg_en", 32'(shreg_en), 32'd0);
      chk("rst_shreg_rst", 32'(shreg_rst), 32'd1);
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_done_mask", 32'(done_mask), 32'd0);
      chk("rst_load_ack", 32'(load_ack), 32'd0);
    end
    rst = 1'b0; load_req = 1'b0;
    #1;
    chk("shreg_en_run", 32'(shreg_en), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("slot_seq", 32'(slot), 32'(i % 4));
      chk("idle_valid", 32'(issue_valid), 32'd0);
      tick();
    end

    // Single block on thread 2: ack only in its slot, then full latency profile.
    load_req = 1'b1; load_thread = 2'd2; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      chk("t2_ack", 32'(load_ack), 32'(exp_slot == 2));
      if (load_ack) got = 1'b1;
      tick();
    end
    load_req = 1'b0;
    chk("t2_acked", 32'(got), 32'd1);
    repeat (3) begin
      chk("t2_wait_valid", 32'(issue_valid), 32'd0);
      tick();
    end
    chk("t2_first", 32'(issue_first), 32'd1);
    chk("t2_first_round", 32'(issue_round), 32'd0);
    chk("t2_first_slot", 32'(slot), 32'd2);
    repeat (4) tick();
    chk("t2_r1_round", 32'(issue_round), 32'd1);
    chk("t2_r1_first", 32'(issue_first), 32'd0);
    repeat (247) tick();
    chk("t2_pre_last_valid", 32'(issue_valid), 32'd0);
    tick();
    chk("t2_last", 32'(issue_last), 32'd1);
    chk("t2_last_round", 32'(issue_round), 32'd63);
    chk("t2_last_mask", 32'(done_mask), 32'd0);
    tick();
    chk("t2_done_mask", 32'(done_mask), 32'h4);
    chk("t2_done_valid", 32'(issue_valid), 32'd0);
    done_ack = 4'b0100;
    tick();
    done_ack = 4'b0000;
    chk("t2_ack_clear", 32'(done_mask), 32'd0);

    // All four threads back-to-back fill every slot.
    for (int i = 0; i < 4; i++) begin
      load_req = 1'b1; load_thread = 2'(exp_slot);
      #1;
      chk("t3_ack", 32'(load_ack), 32'd1);
      tick();
    end
    load_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("t3_valid", 32'(issue_valid), 32'd1);
      chk("t3_round", 32'(issue_round), 32'(i / 4));
      if (i >= 253) chk("t3_done_cnt", 32'($countones(done_mask)), 32'(i - 252));
      tick();
    end
    chk("t3_all_done", 32'(done_mask), 32'hF);
    chk("t3_idle_valid", 32'(issue_valid), 32'd0);
    done_ack = 4'b1111;
    tick();
    done_ack = 4'b0000;
    chk("t3_multi_ack", 32'(done_mask), 32'd0);

    // Random stalls: slot/round frozen while en=0, 257 enabled edges load->done.
    do_load(0, got);
    cnt = 1;
    for (int i = 0; i < 2000 && !done_mask[0]; i++) begin
      en = ($urandom_range(0, 3) != 0);
      prev_slot = slot; prev_round = issue_round; was_en = en;
      tick();
      if (was_en) cnt++;
      else begin
        chk("t4_freeze_slot", 32'(slot), 32'(prev_slot));
        chk("t4_freeze_round", 32'(issue_round), 32'(prev_round));
      end
    end
    chk("t4_enabled_cycles", 32'(cnt), 32'd257);
    chk("t4_slot_track", 32'(slot), 32'(exp_slot));
    en = 1'b0; done_ack = 4'b0001; prev_slot = slot;
    #1;
    chk("t4_stall_shreg_en", 32'(shreg_en), 32'd0);
    tick();
    done_ack = 4'b0000;
    chk("t4_ack_in_stall", 32'(done_mask), 32'd0);
    chk("t4_ack_stall_slot", 32'(slot), 32'(prev_slot));
    en = 1'b1;

    // done_ack and reload of thread 1 in the same cycle.
    do_load(1, got);
    for (int i = 0; i < 400 && !done_mask[1]; i++) tick();
    chk("t5_done_seen", 32'(done_mask), 32'h2);
    for (int i = 0; i < 4 && exp_slot != 1; i++) tick();
    done_ack = 4'b0010; load_req = 1'b1; load_thread = 2'd1;
    #1;
    chk("t5_ack_blocked", 32'(load_ack), 32'd0);
    tick();
    done_ack = 4'b0000;
    chk("t5_mask_cleared", 32'(done_mask), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_other_slot", 32'(load_ack), 32'd0);
      tick();
    end
    #1;
    chk("t5_reload_ack", 32'(load_ack), 32'd1);
    tick();
    load_req = 1'b0;

    // Reset in the middle of thread 0's block drops everything.
    do_load(0, got);
    repeat (123) tick();
    chk("t6_round30", 32'(issue_round), 32'd30);
    chk("t6_valid", 32'(issue_valid), 32'd1);
    chk("t6_slot", 32'(slot), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_shreg_en", 32'(shreg_en), 32'd0);
    tick();
    chk("t6_rst_slot", 32'(slot), 32'd0);
    chk("t6_rst_mask", 32'(done_mask), 32'd0);
    chk("t6_rst_valid", 32'(issue_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_all_idle", 32'(issue_valid), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
